// File: rtl/rca_seq_multiplier.sv
// Unsigned shift-and-add multiplier sequenced over N cycles, sharing a single
// ripple-carry adder between all iterations.
//
// Handshake: a request is taken on any rising edge where start=1 and
// ready=1 (IDLE or DONE). While busy=1 the start input is ignored.
// done pulses for one cycle when product becomes valid. product then holds
// until the next accepted start.

// N-bit ripple-carry adder with carry-out and signed overflow flag.
module rca_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);
    logic [N:0] w_c;

    // Carry ripples from bit 0 upward through one full adder per bit
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < N; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[N];
    assign o_ovf  = w_c[N] ^ w_c[N-1];
endmodule

// Sequential multiplier: one add/shift step per clock while BUSY.
module rca_seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [1:0]     dbg_state
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_m;
    logic [2*N-1:0]  r_p;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_sum;
    logic            w_cy;
    logic            w_unused_ovf;

    // A start is only honoured when the unit can take it (IDLE or DONE)
    assign w_accept = start && (r_state != S_BUSY);
    assign w_last   = (r_count == LAST);

    // The only adder: upper half of the partial product plus the multiplicand
    rca_adder #(.N(N)) u_rca (
        .i_a    (r_p[2*N-1:N]),
        .i_b    (r_m),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cy),
        .o_ovf  (w_unused_ovf)
    );

    // State register; reset abandons any multiplication in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_BUSY;
            S_BUSY:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_BUSY : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then add-if-LSB and shift right
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m     <= '0;
            r_p     <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_m     <= a;
            r_p     <= {{N{1'b0}}, b};
            r_count <= '0;
        end else if (r_state == S_BUSY) begin
            // Carry out of the adder becomes the new top bit after the shift
            if (r_p[0]) begin
                r_p <= {w_cy, w_sum, r_p[N-1:1]};
            end else begin
                r_p <= {1'b0, r_p[2*N-1:1]};
            end
            r_count <= r_count + 1'b1;
        end
    end

    assign product   = r_p;
    assign busy      = (r_state == S_BUSY);
    assign ready     = (r_state != S_BUSY);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_rca_seq_multiplier.sv
// Directed bench for rca_seq_multiplier: an 8-bit instance driven from a
// vector table plus hand-written multi-cycle sequences, and a 32-bit
// instance for the wide-operand case.
module tb_rca_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8, done8;
  logic [15:0] product8;
  logic [1:0]  dbg8;

  logic        start32;
  logic [31:0] a32, b32;
  logic        ready32, busy32, done32;
  logic [63:0] product32;
  logic [1:0]  dbg32;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  // clock / reset
  always #5 clk = ~clk;

  rca_seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8),
    .dbg_state(dbg8)
  );

  rca_seq_multiplier #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .product(product32),
    .dbg_state(dbg32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit multiply (called at a negedge), wait for done, score it.
  task automatic mul8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                      input string name);
    bit seen;
    int lat;
    int nbusy;
    logic [15:0] e;
    exp_q.push_back(exp);
    a8 = ta;
    b8 = tb;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    seen = 0;
    lat = 0;
    nbusy = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        seen = 1;
        lat = k - 1;
      end
    end
    e = exp_q.pop_front();
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'd8);
    chk({name, "_busy_cycles"}, 64'(nbusy), 64'd8);
    chk({name, "_product"}, 64'(product8), 64'(e));
    chk({name, "_ready_in_done"}, 64'(ready8), 64'd1);
  endtask

  // driver + checks
  initial begin
    int ndone;
    int first_at;
    int second_at;
    logic [15:0] first_p;
    logic [15:0] second_p;
    bit seen;
    int lat;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'h000F};
    vecs[1] = '{a: 8'h00,  b: 8'hA5,  exp: 16'h0000};
    vecs[2] = '{a: 8'hA5,  b: 8'h00,  exp: 16'h0000};
    vecs[3] = '{a: 8'd200, b: 8'd100, exp: 16'd20000};
    vecs[4] = '{a: 8'd1,   b: 8'hFF,  exp: 16'h00FF};
    vecs[5] = '{a: 8'h80,  b: 8'd2,   exp: 16'h0100};
    vecs[6] = '{a: 8'hFF,  b: 8'h01,  exp: 16'h00FF};
    vecs[7] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};

    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready8", 64'(ready8), 64'd1);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_product8", 64'(product8), 64'd0);
    chk("rst_ready32", 64'(ready32), 64'd1);
    chk("rst_product32", product32, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      mul8(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), 64'(done8), 64'd0);
    end

    // all-ones operands, then product must hold through idle cycles
    mul8(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("ff_hold%0d", k), 64'(product8), 64'hFE01);
    end
    chk("ff_idle_ready", 64'(ready8), 64'd1);

    // start held high: a changes mid-busy, second request taken in DONE
    a8 = 8'd2;
    b8 = 8'd7;
    start8 = 1'b1;
    @(posedge clk);
    ndone = 0;
    first_at = -1;
    second_at = -1;
    first_p = '0;
    second_p = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) a8 = 8'd9;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          first_at = k - 1;
          first_p = product8;
        end else if (ndone == 2) begin
          second_at = k - 1;
          second_p = product8;
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    chk("held_first_latency", 64'(first_at), 64'd8);
    chk("held_first_product", 64'(first_p), 64'd14);
    chk("held_second_latency", 64'(second_at), 64'd17);
    chk("held_second_product", 64'(second_p), 64'd63);
    chk("held_done_count", 64'(ndone), 64'd2);

    // reset in the middle of a multiply
    @(negedge clk);
    a8 = 8'd100;
    b8 = 8'd200;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy8), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(ready8), 64'd1);
    chk("mid_rst_busy", 64'(busy8), 64'd0);
    chk("mid_rst_product", 64'(product8), 64'd0);
    chk("mid_rst_state", 64'(dbg8), 64'd0);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("mid_rst_no_done", 64'(ndone), 64'd0);
    mul8(8'd12, 8'd12, 16'd144, "after_rst");

    // 32-bit instance
    @(negedge clk);
    a32 = 32'hFFFF_FFFF;
    b32 = 32'h0000_0002;
    start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 50 && !seen; k++) begin
      @(negedge clk);
      if (done32) begin
        seen = 1;
        lat = k - 1;
      end
    end
    chk("w32_done_seen", 64'(seen), 64'd1);
    chk("w32_latency", 64'(lat), 64'd32);
    chk("w32_product", product32, 64'h0000_0001_FFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rca_seq_multiplier.md
Name: rca_seq_multiplier

Overview:
- Multi-cycle unsigned shift-and-add multiplier built around one shared instance of the team's n-bit ripple-carry adder (RCA).
- A small FSM sequences the adder once per cycle for n iterations. Per iteration it adds the multiplicand into the upper half of a 2n-bit partial-product register, then shifts right.
- Sits beside the ALU as the backing unit for MUL/MULHU-class operations; the pipeline drives it with a start/busy/done handshake.

Parameters:
- n, 32, operand width in bits; product is 2n bits; n >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  n  multiplicand; captured on accepted start.
- b  input  n  multiplier; captured on accepted start.
- ready  output  1  1 in IDLE and DONE: a start will be accepted.
- busy  output  1  1 in BUSY.
- done  output  1  one-cycle pulse: product valid.
- product  output  2n  result, held stable from done until the next accepted start.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; M=0; P=0; count=0.
  - Outputs: ready=1, busy=0, done=0, product=0.
  - Overrides everything, including mid-BUSY operation; the partial result is discarded and no done is issued.
- Registers:
  - M[n-1:0]: multiplicand.
  - P[2n-1:0]: partial product and multiplier.
  - count: ceil(log2 n) bits.
  - state: IDLE, BUSY, DONE.
- Adder use: the single RCA instance computes {cy,sum} = P[2n-1:n] + M, with carry-in 0. Its Overflow output is unused. No second adder exists.
- IDLE:
  - start=1 at an edge: M<=a; P<={n'b0,b}; count<=0; ->BUSY.
  - Otherwise stay in IDLE.
- BUSY (one step per edge):
  - If P[0]=1: P <= {cy, sum, P[n-1:1]}.
  - Else: P <= {1'b0, P[2n-1:1]}.
  - count <= count+1.
  - On the step where count==n-1: ->DONE.
  - start is ignored in BUSY; a, b and M are not re-sampled.
- DONE:
  - done=1 and ready=1 for exactly one cycle.
  - If start=1 at this edge: accepted exactly as from IDLE (back-to-back issue) and state ->BUSY.
  - Else ->IDLE.
- Timing:
  - If start is accepted at edge E0, the steps occur at edges E1..En.
  - done is high in the cycle after En, i.e. n cycles after acceptance.
  - Issue-to-issue throughput is n+1 cycles.
- Output rules:
  - product = P, combinationally from the register.
  - product is stable and correct while done=1 and through IDLE until the next accepted start.
  - It is not meaningful during BUSY.
  - busy = (state==BUSY); ready = (state!=BUSY); done = (state==DONE).
- Arithmetic:
  - Result is the exact unsigned 2n-bit product; no truncation and no overflow.
  - The carry out of the RCA always lands in P[2n-1] on the shift.
- Boundaries:
  - a=0 or b=0 gives product=0, still after the full n cycles. There is no early termination.
  - a=b=2^n-1 gives 2^(2n)-2^(n+1)+1; this exercises cy=1 on the top iterations.
  - A start pulse held high across BUSY is not double-counted; it is taken again only in DONE.

Test Plan:
- n=8, reset, then start with a=3, b=5 → busy for 8 cycles, done exactly 8 cycles after acceptance, product=16'h000F.
- n=8, a=8'hFF, b=8'hFF → product=16'hFE01 on done; product stays 16'hFE01 for 5 idle cycles afterwards.
- n=8, a=0, b=8'hA5 → done after 8 cycles, product=0; then a=8'hA5, b=0 → product=0.
- n=8, start held high continuously with a=2, b=7 and a changed to 9 at cycle 3 → first done gives product=14. Second accepted start in the DONE cycle (a=9) gives done 9 cycles after the first done with product 63.
- n=8, a=100, b=200, rst=0 at cycle 4 of BUSY → next cycle ready=1, busy=0, product=0, and no done pulse ever appears. Then 12*12 gives 144.
- n=32, a=32'hFFFF_FFFF, b=32'h0000_0002 → done after 32 cycles, product=64'h0000_0001_FFFF_FFFE.
